// File: rtl/booth_accumulator.sv
// rtl/booth_accumulator.sv - serial radix-8 Booth partial-product accumulator with valid/ready result
// Optional overflow flag output enabled by defining BOOTH_ACCUMULATOR_OVF_EN.
module booth_accumulator #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_TERMS  = (DATA_WIDTH + 3) / 3,
    parameter int PP_WIDTH   = 2 * DATA_WIDTH - 1,
    parameter int ACC_WIDTH  = 3 * (NUM_TERMS - 1) + PP_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_TERMS*PP_WIDTH-1:0]   pp_bus,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [2*DATA_WIDTH-1:0]         result,
    output logic                            out_valid,
    input  logic                            out_ready,
`ifdef BOOTH_ACCUMULATOR_OVF_EN
    output logic                            ovf,
`endif
    output logic                            busy
);

    localparam int IDX_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int RES_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                          state, state_next;
    logic [ACC_WIDTH-1:0]            acc, acc_next;
    logic [IDX_W-1:0]                idx, idx_next;
    logic [NUM_TERMS*PP_WIDTH-1:0]   bus_q, bus_next;

    logic [PP_WIDTH-1:0]             term;
    logic [ACC_WIDTH-1:0]            term_ext;
    logic [ACC_WIDTH-1:0]            addend;

    // Each term carries weight 8^idx; sign extension happens before the shift so
    // negative digits borrow through the full accumulator width.
    always_comb begin
        term     = bus_q[int'(idx)*PP_WIDTH +: PP_WIDTH];
        term_ext = {{(ACC_WIDTH-PP_WIDTH){term[PP_WIDTH-1]}}, term};
        addend   = term_ext << (3 * int'(idx));
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        idx_next   = idx;
        bus_next   = bus_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    bus_next   = pp_bus;
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                acc_next = acc + addend;
                if (idx == IDX_W'(NUM_TERMS - 1)) begin
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            bus_q <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            idx   <= idx_next;
            bus_q <= bus_next;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = out_valid ? acc[RES_W-1:0] : '0;

`ifdef BOOTH_ACCUMULATOR_OVF_EN
    // Any set bit above the product range means a negative or oversized total.
    assign ovf = out_valid && (|acc[ACC_WIDTH-1:RES_W]);
`endif

endmodule

// File: tb/tb_booth_accumulator.sv
// tb/tb_booth_accumulator.sv - directed self-checking bench for booth_accumulator
module tb_booth_accumulator;

    localparam int DW  = 6;
    localparam int NT  = 3;
    localparam int PPW = 11;
    localparam int BW  = NT * PPW;

    logic            clk = 1'b0;
    logic            rst;
    logic [BW-1:0]   pp_bus;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] result;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
`ifdef BOOTH_ACCUMULATOR_OVF_EN
    logic            ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .pp_bus    (pp_bus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BOOTH_ACCUMULATOR_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [BW-1:0]   bus;
        logic [2*DW-1:0] exp_res;
        logic            exp_ovf;
        string           name;
    } vec_t;

    vec_t vecs [7];

    localparam logic [BW-1:0] BUS_A = {11'h000, 11'h09F, 11'h09F};
    localparam logic [BW-1:0] BUS_B = {11'h000, 11'h035, 11'h7CB};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one bus, require out_valid exactly 4 edges after the accept edge, then handshake.
    task automatic run_op(input logic [BW-1:0] bus, input logic [2*DW-1:0] exp_res,
                          input logic exp_ovf, input string name);
        int cyc;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        pp_bus   = bus;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        pp_bus   = '0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'd4);
        check({name, "_result"}, 32'(result), 32'(exp_res));
`ifdef BOOTH_ACCUMULATOR_OVF_EN
        check({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) check({name, "_ovf_unused"}, 32'd0, 32'd1);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{BUS_A, 12'h597, 1'b0, "basic_53x27"};
        vecs[1] = '{BUS_B, 12'h173, 1'b0, "neg_digit_53x7"};
        vecs[2] = '{{11'h000, 11'h000, 11'h7FF}, 12'hFFF, 1'b1, "minus_one"};
        vecs[3] = '{'0, 12'h000, 1'b0, "all_zero"};
        vecs[4] = '{{11'h7FF, 11'h000, 11'h000}, 12'hFC0, 1'b1, "neg_high"};
        vecs[5] = '{{11'h000, 11'h7FD, 11'h005}, 12'hFED, 1'b1, "neg_mid"};
        vecs[6] = '{{11'h3FF, 11'h3FF, 11'h3FF}, 12'h3B7, 1'b1, "max_pos_wrap"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pp_bus = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
`ifdef BOOTH_ACCUMULATOR_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].bus, vecs[i].exp_res, vecs[i].exp_ovf, vecs[i].name);

        // Backpressure: hold result for 5 cycles while in_valid pulses are ignored.
        @(negedge clk);
        pp_bus = BUS_A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'd4);
        for (int k = 0; k < 5; k++) begin
            pp_bus   = BUS_B;
            in_valid = k[0];
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(result), 32'h597);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_no_stray_accept", 32'(busy), 32'd0);

        // Reset on the second ACCUM cycle discards the operation.
        pp_bus = BUS_B; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_result", 32'(result), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        run_op(BUS_A, 12'h597, 1'b0, "after_rst");

        // Reset while a result is pending in DONE.
        pp_bus = BUS_A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstdone_pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstdone_out_valid", 32'(out_valid), 32'd0);
        check("rstdone_result", 32'(result), 32'd0);

        // Back-to-back with in_valid held: second accept one cycle after the first handshake.
        @(negedge clk);
        pp_bus = BUS_A; in_valid = 1'b1;
        @(negedge clk);
        pp_bus = BUS_B;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", 32'(cyc), 32'd4);
        check("b2b_first_result", 32'(result), 32'h597);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle_between", 32'(in_ready), 32'd1);
        check("b2b_valid_dropped", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_second_accept", 32'(busy), 32'd1);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_latency", 32'(cyc), 32'd4);
        check("b2b_second_result", 32'(result), 32'h173);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_end_idle", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
